// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-RAM arbiter: read-owner tags, requester
// indices, round-robin pointer encodings and the default read latency.
package mem_arb_pkg;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_CPU  = 2'b01;
  localparam logic [1:0] TAG_VGA  = 2'b10;
  localparam logic [1:0] TAG_IO   = 2'b11;

  localparam int REQ_CPU = 0;
  localparam int REQ_VGA = 1;
  localparam int REQ_IO  = 2;
  localparam int NUM_REQ = 3;

  localparam int DEFAULT_RD_LAT = 1;

  // Round-robin pointer: which of CPU/IO wins a CPU-vs-IO tie next
  localparam logic [0:0] RR_CPU = 1'b0;
  localparam logic [0:0] RR_IO  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_arbiter; the arbiter takes
// the slave modport, the requesters/RAM side the master modport.
interface mem_arbiter_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 14
);
  // Handshake: a requester raises req with we/addr/wdata and holds all of them
  // stable until it samples gnt==1 at a clock edge; gnt is a one-cycle pulse and
  // the next request may be presented in the cycle after gnt. Read data comes
  // back on the shared rdata bus, qualified by that requester's rvalid pulse.
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [WIDTH-1:0]     cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_rvalid;

  logic                 vga_req;
  logic [ADDR_BITS-1:0] vga_addr;
  logic                 vga_gnt;
  logic                 vga_rvalid;

  logic                 io_req;
  logic                 io_we;
  logic [ADDR_BITS-1:0] io_addr;
  logic [WIDTH-1:0]     io_wdata;
  logic                 io_gnt;
  logic                 io_rvalid;

  logic [WIDTH-1:0]     rdata;

  logic [ADDR_BITS-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 mem_we;
  logic [WIDTH-1:0]     mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vga_req, vga_addr,
    input  io_req, io_we, io_addr, io_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, io_gnt, io_rvalid,
    output rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vga_req, vga_addr,
    output io_req, io_we, io_addr, io_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, io_gnt, io_rvalid,
    input  rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter_tag_pipe.sv
// arb_tag_pipe: RD_LAT-deep shift register of read-owner tags; the tag at the
// far end selects which requester's rvalid strobe fires this cycle.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = DEFAULT_RD_LAT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tag_in,
  output logic       cpu_rvalid,
  output logic       vga_rvalid,
  output logic       io_rvalid
);

  logic [RD_LAT-1:0][1:0] stage;
  logic [1:0]             tag_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out    = stage[RD_LAT-1];
  assign cpu_rvalid = (tag_out == TAG_CPU);
  assign vga_rvalid = (tag_out == TAG_VGA);
  assign io_rvalid  = (tag_out == TAG_IO);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-RAM port between CPU, VGA fetcher and I/O bridge.
// Optional starvation guard on VGA priority is enabled by ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int ADDR_BITS    = 14,
  parameter int RD_LAT       = DEFAULT_RD_LAT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  logic       cpu_elig, vga_elig, io_elig;
  logic       rr_cpu, rr_io;
  logic       starve;
  logic       win_cpu, win_vga, win_io;
  logic [0:0] rr_ptr;
  logic [1:0] issue_tag;

  // A requester whose grant is showing this cycle is still holding its old
  // request, so it must sit out this decision.
  assign cpu_elig = bus.cpu_req & ~bus.cpu_gnt;
  assign vga_elig = bus.vga_req & ~bus.vga_gnt;
  assign io_elig  = bus.io_req  & ~bus.io_gnt;

  assign rr_cpu = cpu_elig & (~io_elig  | (rr_ptr == RR_CPU));
  assign rr_io  = io_elig  & (~cpu_elig | (rr_ptr == RR_IO));

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT)) & (cpu_elig | io_elig);

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (win_cpu | win_io | ~(bus.cpu_req | bus.io_req)) begin
      starve_cnt <= '0;
    end else if (win_vga & (cpu_elig | io_elig)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  assign win_vga = vga_elig & ~starve;
  assign win_cpu = ~win_vga & rr_cpu;
  assign win_io  = ~win_vga & rr_io;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.cpu_gnt   <= 1'b0;
      bus.vga_gnt   <= 1'b0;
      bus.io_gnt    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_BITS{1'b0}};
      bus.mem_wdata <= {WIDTH{1'b0}};
      rr_ptr        <= RR_CPU;
    end else begin
      bus.cpu_gnt <= win_cpu;
      bus.vga_gnt <= win_vga;
      bus.io_gnt  <= win_io;
      bus.mem_we  <= (win_cpu & bus.cpu_we) | (win_io & bus.io_we);
      if (win_cpu) begin
        bus.mem_addr  <= bus.cpu_addr;
        bus.mem_wdata <= bus.cpu_wdata;
        rr_ptr        <= RR_IO;
      end else if (win_io) begin
        bus.mem_addr  <= bus.io_addr;
        bus.mem_wdata <= bus.io_wdata;
        rr_ptr        <= RR_CPU;
      end else if (win_vga) begin
        bus.mem_addr  <= bus.vga_addr;
      end
    end
  end

  // Tag the access visible on the RAM port this cycle; writes carry no owner.
  always_comb begin
    issue_tag = TAG_NONE;
    if (!bus.mem_we) begin
      if (bus.cpu_gnt)      issue_tag = TAG_CPU;
      else if (bus.vga_gnt) issue_tag = TAG_VGA;
      else if (bus.io_gnt)  issue_tag = TAG_IO;
    end
  end

  arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .tag_in     (issue_tag),
    .cpu_rvalid (bus.cpu_rvalid),
    .vga_rvalid (bus.vga_rvalid),
    .io_rvalid  (bus.io_rvalid)
  );

  assign bus.rdata = (bus.cpu_rvalid | bus.vga_rvalid | bus.io_rvalid) ?
                     bus.mem_rdata : {WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: queued requester drivers, a RAM model,
// and a rule-level reference model with a per-cycle scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int WIDTH        = 16;
  localparam int ADDR_BITS    = 14;
  localparam int RD_LAT       = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int TW           = 1 + ADDR_BITS + WIDTH;
  localparam int EW           = 32 + 2 + WIDTH;
  localparam int RAM_N        = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  mem_arbiter_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

  mem_arbiter #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model (RD_LAT cycles from mem_* to mem_rdata)
  logic [WIDTH-1:0] ram [RAM_N];
  logic [WIDTH-1:0] rd_pipe [RD_LAT];
  logic             ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      foreach (ram[i]) ram[i] <= '0;
      ram_init <= 1'b1;
    end else begin
      rd_pipe[0] <= ram[bus.mem_addr[5:0]];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (bus.mem_we) ram[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- requester drivers: queues of {we, addr, wdata}
  logic [TW-1:0] cpu_q[$], vga_q[$], io_q[$];
  logic cpu_busy = 1'b0, vga_busy = 1'b0, io_busy = 1'b0;
  logic cpu_gs = 1'b0, vga_gs = 1'b0, io_gs = 1'b0;

  always @(negedge clk) begin
    cpu_gs = bus.cpu_gnt;
    vga_gs = bus.vga_gnt;
    io_gs  = bus.io_gnt;
  end

  always @(posedge clk) begin
    logic            dw;
    logic [WIDTH-1:0] dd;
    #1;
    if (!reset) begin
      cpu_busy = 1'b0; vga_busy = 1'b0; io_busy = 1'b0;
    end else begin
      if (cpu_busy && cpu_gs) cpu_busy = 1'b0;
      if (vga_busy && vga_gs) vga_busy = 1'b0;
      if (io_busy && io_gs)   io_busy = 1'b0;
      if (!cpu_busy && cpu_q.size() > 0) begin
        {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata} = cpu_q.pop_front();
        cpu_busy = 1'b1;
      end
      if (!vga_busy && vga_q.size() > 0) begin
        {dw, bus.vga_addr, dd} = vga_q.pop_front();
        vga_busy = 1'b1;
      end
      if (!io_busy && io_q.size() > 0) begin
        {bus.io_we, bus.io_addr, bus.io_wdata} = io_q.pop_front();
        io_busy = 1'b1;
      end
    end
    bus.cpu_req = cpu_busy;
    bus.vga_req = vga_busy;
    bus.io_req  = io_busy;
  end

  // ---------------- reference model: arbitration rules applied per edge
  logic [1:0]       m_gnt = TAG_NONE;
  logic             m_pref_io = 1'b0;
  int               m_cnt = 0;
  logic             m_we = 1'b0;
  logic [ADDR_BITS-1:0] m_addr = '0;
  logic [WIDTH-1:0] m_wdata = '0;
  logic [WIDTH-1:0] model_ram [RAM_N];
  logic             mram_init = 1'b0;
  logic [EW-1:0]    exp_q[$];

  always @(posedge clk) begin
    logic ce, ve, ie, starve;
    logic [1:0] rr, win;
    cyc++;
    if (!mram_init) begin
      foreach (model_ram[i]) model_ram[i] = '0;
      mram_init = 1'b1;
    end
    if (!reset) begin
      m_gnt = TAG_NONE; m_pref_io = 1'b0; m_cnt = 0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0;
      exp_q.delete();
    end else begin
      ce = bus.cpu_req && (m_gnt != TAG_CPU);
      ve = bus.vga_req && (m_gnt != TAG_VGA);
      ie = bus.io_req  && (m_gnt != TAG_IO);
      if (ce && ie) rr = m_pref_io ? TAG_IO : TAG_CPU;
      else if (ce)  rr = TAG_CPU;
      else if (ie)  rr = TAG_IO;
      else          rr = TAG_NONE;
      starve = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve = (m_cnt == STARVE_LIMIT) && (rr != TAG_NONE);
`endif
      win = (ve && !starve) ? TAG_VGA : rr;
`ifdef ARB_STARVE_GUARD_EN
      if (win == TAG_CPU || win == TAG_IO || (!bus.cpu_req && !bus.io_req)) m_cnt = 0;
      else if (win == TAG_VGA && (ce || ie)) m_cnt++;
`endif
      m_gnt = win;
      m_we  = 1'b0;
      case (win)
        TAG_CPU: begin m_pref_io = 1'b1; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata; m_we = bus.cpu_we; end
        TAG_IO:  begin m_pref_io = 1'b0; m_addr = bus.io_addr;  m_wdata = bus.io_wdata;  m_we = bus.io_we;  end
        TAG_VGA: m_addr = bus.vga_addr;
        default: ;
      endcase
      if (win != TAG_NONE) begin
        if (m_we) model_ram[m_addr[5:0]] = m_wdata;
        else exp_q.push_back({32'(cyc + RD_LAT), win, model_ram[m_addr[5:0]]});
      end
    end
  end

  // ---------------- scoreboard: every cycle against the model
  logic [WIDTH+2:0] glog[$];   // observed grants {owner, we, wdata}
  logic [WIDTH+1:0] rvlog[$];  // observed returns {owner, rdata}

  always @(negedge clk) begin
    logic [2:0] eg, er, og;
    logic [1:0] ro, oo;
    logic [WIDTH-1:0] rd;
    logic [EW-1:0] e;
    if (chk_en) begin
      eg = {m_gnt == TAG_CPU, m_gnt == TAG_VGA, m_gnt == TAG_IO};
      og = {bus.cpu_gnt, bus.vga_gnt, bus.io_gnt};
      n_checks++;
      if (og !== eg) begin n_fail++; $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, og, eg); end
      n_checks++;
      if (bus.mem_we !== m_we) begin n_fail++; $display("FAIL mem_we cyc=%0d got=%b want=%b", cyc, bus.mem_we, m_we); end
      n_checks++;
      if (bus.mem_addr !== m_addr) begin n_fail++; $display("FAIL mem_addr cyc=%0d got=%h want=%h", cyc, bus.mem_addr, m_addr); end
      n_checks++;
      if (bus.mem_wdata !== m_wdata) begin n_fail++; $display("FAIL mem_wdata cyc=%0d got=%h want=%h", cyc, bus.mem_wdata, m_wdata); end
      ro = TAG_NONE; rd = '0;
      if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] == cyc) begin
        e = exp_q.pop_front(); ro = e[WIDTH+1 -: 2]; rd = e[WIDTH-1:0];
      end
      er = {ro == TAG_CPU, ro == TAG_VGA, ro == TAG_IO};
      n_checks++;
      if ({bus.cpu_rvalid, bus.vga_rvalid, bus.io_rvalid} !== er) begin
        n_fail++; $display("FAIL rvalid cyc=%0d got=%b want=%b", cyc, {bus.cpu_rvalid, bus.vga_rvalid, bus.io_rvalid}, er);
      end
      n_checks++;
      if (bus.rdata !== rd) begin n_fail++; $display("FAIL rdata cyc=%0d got=%h want=%h", cyc, bus.rdata, rd); end
      oo = bus.cpu_gnt ? TAG_CPU : bus.vga_gnt ? TAG_VGA : bus.io_gnt ? TAG_IO : TAG_NONE;
      if (oo != TAG_NONE) glog.push_back({oo, bus.mem_we, bus.mem_wdata});
      oo = bus.cpu_rvalid ? TAG_CPU : bus.vga_rvalid ? TAG_VGA : bus.io_rvalid ? TAG_IO : TAG_NONE;
      if (oo != TAG_NONE) rvlog.push_back({oo, bus.rdata});
    end
  end

  // ---------------- helpers (called at negedge)
  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while ((cpu_q.size() > 0 || vga_q.size() > 0 || io_q.size() > 0 || cpu_busy || vga_busy ||
            io_busy || exp_q.size() > 0) && k < budget) begin
      @(negedge clk); k++;
    end
    n_checks++;
    if (k >= budget) begin n_fail++; $display("FAIL %s drain: still busy after %0d cycles, required idle", name, k); end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scenarios
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.cpu_gnt, bus.vga_gnt, bus.io_gnt, bus.cpu_rvalid, bus.vga_rvalid, bus.io_rvalid, bus.mem_we} !== 7'b0 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.rdata !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got addr=%h wdata=%h rdata=%h we=%b, required all 0",
                         bus.mem_addr, bus.mem_wdata, bus.rdata, bus.mem_we);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    glog.delete(); rvlog.delete();
    cpu_q.push_back({1'b1, 14'h0010, 16'hBEEF});
    cpu_q.push_back({1'b0, 14'h0010, 16'h0000});
    wait_drain(50, "write_read");
    n_checks++;
    if (glog.size() != 2) begin n_fail++; $display("FAIL wr_grant_count got=%0d want=2", glog.size()); end
    n_checks++;
    if (glog[0] !== {TAG_CPU, 1'b1, 16'hBEEF}) begin n_fail++; $display("FAIL wr_first_grant got=%h want=%h", glog[0], {TAG_CPU, 1'b1, 16'hBEEF}); end
    n_checks++;
    if (rvlog.size() != 1 || rvlog[0] !== {TAG_CPU, 16'hBEEF}) begin
      n_fail++; $display("FAIL rd_return got n=%0d first=%h want one %h", rvlog.size(), rvlog[0], {TAG_CPU, 16'hBEEF});
    end
  endtask

  task automatic test_all_three;
    do_reset(2);
    glog.delete(); rvlog.delete();
    cpu_q.push_back({1'b0, 14'h0010, 16'h0});
    vga_q.push_back({1'b0, 14'h0020, 16'h0});
    io_q.push_back({1'b0, 14'h0030, 16'h0});
    wait_drain(50, "all_three");
    n_checks++;
    if (glog.size() != 3 || glog[0][WIDTH+2 -: 2] !== TAG_VGA || glog[1][WIDTH+2 -: 2] !== TAG_CPU ||
        glog[2][WIDTH+2 -: 2] !== TAG_IO) begin
      n_fail++; $display("FAIL all_three_grant_order got n=%0d %h %h %h, want VGA CPU IO", glog.size(), glog[0], glog[1], glog[2]);
    end
    n_checks++;
    if (rvlog.size() != 3 || rvlog[0][WIDTH+1 -: 2] !== TAG_VGA || rvlog[1][WIDTH+1 -: 2] !== TAG_CPU ||
        rvlog[2][WIDTH+1 -: 2] !== TAG_IO) begin
      n_fail++; $display("FAIL all_three_return_order got n=%0d, want VGA CPU IO", rvlog.size());
    end
  endtask

  task automatic test_alternate;
    glog.delete();
    for (int i = 0; i < 6; i++) begin
      cpu_q.push_back({1'b0, 14'($urandom_range(0, 63)), 16'($urandom)});
      io_q.push_back({1'b0, 14'($urandom_range(0, 63)), 16'($urandom)});
    end
    wait_drain(100, "alternate");
    n_checks++;
    if (glog.size() != 12) begin n_fail++; $display("FAIL alt_count got=%0d want=12", glog.size()); end
    for (int i = 1; i < glog.size(); i++) begin
      n_checks++;
      if (glog[i][WIDTH+2 -: 2] === glog[i-1][WIDTH+2 -: 2]) begin
        n_fail++; $display("FAIL alt_repeat idx=%0d owner=%0d granted twice in a row, required alternation", i, glog[i][WIDTH+2 -: 2]);
      end
    end
  endtask

  task automatic test_vga_pressure;
    int nc, nv;
    glog.delete();
    for (int i = 0; i < 10; i++) vga_q.push_back({1'b0, 14'($urandom_range(0, 63)), 16'h0});
    for (int i = 0; i < 4; i++)  cpu_q.push_back({1'b0, 14'($urandom_range(0, 63)), 16'h0});
    wait_drain(100, "vga_pressure");
    nc = 0; nv = 0;
    foreach (glog[i]) begin
      if (glog[i][WIDTH+2 -: 2] == TAG_CPU) nc++;
      if (glog[i][WIDTH+2 -: 2] == TAG_VGA) nv++;
    end
    n_checks++;
    if (nc != 4 || nv != 10) begin n_fail++; $display("FAIL pressure_counts got cpu=%0d vga=%0d want cpu=4 vga=10", nc, nv); end
  endtask

  task automatic test_reset_inflight;
    int k = 0;
    vga_q.push_back({1'b0, 14'h0011, 16'h0});
    while (!bus.vga_gnt && k < 20) begin @(negedge clk); k++; end
    n_checks++;
    if (!bus.vga_gnt) begin
      n_fail++; $display("FAIL inflight_grant: no vga_gnt within 20 cycles, required 1");
    end else begin
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.cpu_gnt, bus.vga_gnt, bus.io_gnt, bus.cpu_rvalid, bus.vga_rvalid, bus.io_rvalid, bus.mem_we} !== 7'b0 ||
          bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.rdata !== '0) begin
        n_fail++; $display("FAIL inflight_reset_outputs got addr=%h rdata=%h, required all 0", bus.mem_addr, bus.rdata);
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        n_checks++;
        if (bus.vga_rvalid !== 1'b0) begin n_fail++; $display("FAIL inflight_dropped cyc=%0d vga_rvalid=%b want 0", cyc, bus.vga_rvalid); end
      end
    end
  endtask

  task automatic test_vga_io_write;
    logic [WIDTH-1:0] d;
    d = 16'($urandom);
    glog.delete();
    vga_q.push_back({1'b0, 14'($urandom_range(0, 63)), 16'h0});
    io_q.push_back({1'b1, 14'h0025, d});
    wait_drain(50, "vga_io_write");
    n_checks++;
    if (glog.size() != 2 || glog[0][WIDTH+2 -: 3] !== {TAG_VGA, 1'b0}) begin
      n_fail++; $display("FAIL vga_first_no_we got n=%0d first=%h, want VGA with mem_we=0", glog.size(), glog[0]);
    end
    n_checks++;
    if (glog[1] !== {TAG_IO, 1'b1, d}) begin n_fail++; $display("FAIL io_write_next got=%h want=%h", glog[1], {TAG_IO, 1'b1, d}); end
  endtask

  task automatic test_random;
    int pushed = 0;
    glog.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (cpu_q.size() < 2 && $urandom_range(0, 2) == 0) begin
        cpu_q.push_back({1'($urandom_range(0, 1)), 14'($urandom_range(0, 31)), 16'($urandom)}); pushed++;
      end
      if (vga_q.size() < 2 && $urandom_range(0, 2) == 0) begin
        vga_q.push_back({1'b0, 14'($urandom_range(0, 31)), 16'h0}); pushed++;
      end
      if (io_q.size() < 2 && $urandom_range(0, 2) == 0) begin
        io_q.push_back({1'($urandom_range(0, 1)), 14'($urandom_range(0, 31)), 16'($urandom)}); pushed++;
      end
    end
    wait_drain(200, "random");
    n_checks++;
    if (glog.size() != pushed) begin n_fail++; $display("FAIL random_grant_total got=%0d want=%0d", glog.size(), pushed); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_three();
    test_alternate();
    test_vga_pressure();
    test_reset_inflight();
    test_vga_io_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
